// File: rtl/sram_controller.sv
// Multi-cycle bridge from the MEM-stage load/store request to a 16-bit async SRAM.
// Each 32-bit word is moved as two halfword accesses; ready stalls the pipeline meanwhile.
module sram_controller #(
   parameter int          ACCESS_CYCLES = 5,
   parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] sram_dq,
   output logic [17:0] sram_addr,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n,
   output logic        sram_ce_n,
   output logic        sram_oe_n
);

   typedef enum logic [2:0] {IDLE, LO, HI, WAIT, DONE} state_t;

   localparam int           CW   = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] count;
   logic          is_write;
   logic [15:0]   dq_out;
   logic          dq_oe;
   logic [16:0]   line;

   // SRAM word index of the request; the byte offset in address[1:0] is dropped.
   assign line = 17'((address - BASE_ADDR) >> 2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         is_write  <= 1'b0;
         read_data <= '0;
         sram_addr <= '0;
         sram_we_n <= 1'b1;
         dq_out    <= '0;
         dq_oe     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en || rd_en) begin
                  state     <= LO;
                  count     <= CW'(1);
                  is_write  <= wr_en;
                  sram_addr <= {line, 1'b0};
                  sram_we_n <= !wr_en;
                  dq_oe     <= wr_en;
                  dq_out    <= write_data[15:0];
               end
            end
            LO: begin
               if (!is_write) read_data[15:0] <= sram_dq;
               state     <= HI;
               count     <= count + 1'b1;
               sram_addr <= {line, 1'b1};
               dq_out    <= write_data[31:16];
            end
            HI: begin
               if (!is_write) read_data[31:16] <= sram_dq;
               sram_we_n <= 1'b1;
               dq_oe     <= 1'b0;
               count     <= count + 1'b1;
               state     <= (ACCESS_CYCLES <= 3) ? DONE : WAIT;
            end
            WAIT: begin
               count <= count + 1'b1;
               if (count == LAST) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
               count <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // IDLE drops ready combinationally so the requesting instruction freezes in place.
   always_comb begin
      ready = 1'b0;
      if (state == IDLE) ready = !(rd_en || wr_en);
      else if (state == DONE) ready = 1'b1;
   end

   assign sram_dq   = dq_oe ? dq_out : 16'hzzzz;
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;
   assign sram_ce_n = 1'b0;
   assign sram_oe_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller with a word-level memory reference model,
// plus a second instance at the minimum access time.
module tb_sram_controller;

   localparam int AC = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = !clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- main instance (ACCESS_CYCLES = 5) ----------------
   logic        wr_en = 0, rd_en = 0;
   logic [31:0] address = 0, write_data = 0, read_data;
   logic        ready, sram_we_n, ub_n, lb_n, ce_n, oe_n;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;

   sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(32'd1024)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready), .sram_dq(sram_dq),
      .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n),
      .sram_ce_n(ce_n), .sram_oe_n(oe_n));

   // Async SRAM model: drives the bus whenever it is not being written.
   logic [15:0] smem [0:1023];
   assign sram_dq = sram_we_n ? smem[sram_addr[9:0]] : 16'hzzzz;
   always @(posedge clk) if (!sram_we_n) smem[sram_addr[9:0]] <= sram_dq;

   // ---------------- second instance (ACCESS_CYCLES = 3) ----------------
   logic        wr3 = 0, rd3 = 0;
   logic [31:0] addr3 = 0, wd3 = 0, rdata3;
   logic        ready3, we3_n, ub3, lb3, ce3, oe3;
   logic [17:0] saddr3;
   wire  [15:0] dq3;

   sram_controller #(.ACCESS_CYCLES(3), .BASE_ADDR(32'd1024)) dut3 (
      .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3), .address(addr3),
      .write_data(wd3), .read_data(rdata3), .ready(ready3), .sram_dq(dq3),
      .sram_addr(saddr3), .sram_we_n(we3_n), .sram_ub_n(ub3), .sram_lb_n(lb3),
      .sram_ce_n(ce3), .sram_oe_n(oe3));

   logic [15:0] mem3 [0:15];
   assign dq3 = we3_n ? mem3[saddr3[3:0]] : 16'hzzzz;
   always @(posedge clk) if (!we3_n) mem3[saddr3[3:0]] <= dq3;

   // ---------------- reference model and scoreboard ----------------
   logic [31:0] ref_mem [0:511];

   typedef struct {
      bit          is_read;
      logic [31:0] data;
      logic [31:0] addr;
      int          issue;
   } txn_t;
   txn_t q[$];

   function automatic int widx(input logic [31:0] a);
      return int'((a - 32'd1024) >> 2);
   endfunction

   always @(negedge clk) begin
      if (!rst && q.size() > 0) begin
         txn_t t;
         int   d;
         int   hw;
         t  = q[0];
         d  = cyc - t.issue;
         hw = 2 * widx(t.addr);
         if (!t.is_read && d == 1) begin
            chk("wr_lo_addr", 32'(sram_addr), 32'(hw));
            chk("wr_lo_we_n", 32'(sram_we_n), 32'd0);
            chk("wr_lo_dq", 32'(sram_dq), {16'h0, t.data[15:0]});
         end
         if (!t.is_read && d == 2) begin
            chk("wr_hi_addr", 32'(sram_addr), 32'(hw + 1));
            chk("wr_hi_we_n", 32'(sram_we_n), 32'd0);
            chk("wr_hi_dq", 32'(sram_dq), {16'h0, t.data[31:16]});
         end
         if ((t.is_read || d >= 3) && d >= 1) chk("we_n_idle", 32'(sram_we_n), 32'd1);
         if (ready) begin
            chk("latency", 32'(d), 32'(AC));
            if (t.is_read) chk("read_data", read_data, t.data);
            void'(q.pop_front());
         end else if (d > AC + 8) begin
            chk("ready_timeout", 32'(d), 32'(AC));
            void'(q.pop_front());
         end
      end
   end

   task automatic do_op(input bit wr, input logic [31:0] a, input logic [31:0] d);
      txn_t t;
      bit   seen;
      @(posedge clk); #1;
      wr_en = wr; rd_en = !wr; address = a; write_data = d;
      t.is_read = !wr;
      t.addr    = a;
      t.issue   = cyc;
      if (wr) begin
         ref_mem[widx(a)] = d;
         t.data = d;
      end else begin
         t.data = ref_mem[widx(a)];
      end
      q.push_back(t);
      seen = 0;
      for (int i = 0; i < AC + 10 && !seen; i++) begin
         @(negedge clk);
         if (ready && cyc > t.issue) seen = 1;
      end
      if (!seen) chk("driver_wait", 32'd0, 32'd1);
   endtask

   task automatic go_idle(input int n);
      @(posedge clk); #1;
      wr_en = 0; rd_en = 0;
      if (n > 1) repeat (n - 1) @(posedge clk);
   endtask

   task automatic do3(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output int lat);
      int  iss;
      bit  seen;
      @(posedge clk); #1;
      wr3 = wr; rd3 = !wr; addr3 = a; wd3 = d;
      iss = cyc; seen = 0; lat = -1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (ready3 && cyc > iss) begin seen = 1; lat = cyc - iss; end
      end
      @(posedge clk); #1;
      wr3 = 0; rd3 = 0;
   endtask

   initial begin
      int          lat;
      int          xi;
      logic [31:0] a, d;
      for (int i = 0; i < 1024; i++) smem[i] = 16'h0;
      for (int i = 0; i < 16; i++) mem3[i] = 16'h0;
      for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;

      // Reset hold 2 cycles
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_read_data", read_data, 32'h0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("tied_strobes", {28'h0, ub_n, lb_n, ce_n, oe_n}, 32'h0);

      // Directed cases
      do_op(1, 32'd1024, 32'hDEADBEEF);
      go_idle(1);
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      do_op(0, 32'd1024, 32'h0);
      go_idle(2);
      do_op(1, 32'd1032, 32'h12345678);
      do_op(0, 32'd1033, 32'h0);
      go_idle(1);
      // Back-to-back: read then write with no gap
      do_op(0, 32'd1024, 32'h0);
      do_op(1, 32'd1028, 32'hA5A55A5A);
      do_op(0, 32'd1028, 32'h0);
      go_idle(2);

      // Randomized traffic with occasional gaps
      for (int n = 0; n < 200; n++) begin
         a = 32'd1024 + 32'($urandom_range(0, 2047));
         if ($urandom_range(0, 3) == 0) a = 32'd1024 + 32'($urandom_range(0, 15));
         d = $urandom;
         do_op($urandom_range(0, 1) == 1, a, d);
         if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 3));
      end
      go_idle(3);
      chk("queue_drained", 32'(q.size()), 32'd0);

      // Reset during WAIT of a write (both halves already stored)
      xi = 100;
      @(posedge clk); #1;
      wr_en = 1; rd_en = 0; address = 32'd1024 + 32'(4 * xi); write_data = 32'h0BADF00D;
      repeat (3) @(posedge clk);
      #1 rst = 1; wr_en = 0;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_read_data", read_data, 32'h0);
      ref_mem[xi] = 32'h0BADF00D;
      do_op(0, 32'd1024 + 32'(4 * xi), 32'h0);
      go_idle(3);

      // Minimum access time instance
      do3(1, 32'd1032, 32'hCAFEF00D, lat);
      chk("ac3_wr_latency", 32'(lat), 32'd3);
      do3(0, 32'd1034, 32'h0, lat);
      chk("ac3_rd_latency", 32'(lat), 32'd3);
      chk("ac3_read_data", rdata3, 32'hCAFEF00D);
      chk("ac3_mem_lo", {16'h0, mem3[4]}, 32'h0000F00D);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=%0d expected=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Multi-cycle controller between the MEM stage's memory request signals and the board's external 16-bit asynchronous SRAM.
- Consumes the MEM stage request: read/write enables, ALU-result address, Val_Rm store data.
- Splits each 32-bit word into two 16-bit SRAM accesses.
- Drops ready for the duration of an access; the hazard/freeze logic uses ready to stall every pipeline register.

Parameters:
ACCESS_CYCLES, 5, cycles from request acceptance to ready=1 (minimum 3)
BASE_ADDR, 1024, byte address mapped to SRAM word 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
wr_en  input  1  store request from MEM stage
rd_en  input  1  load request from MEM stage
address  input  32  byte address (ALU result)
write_data  input  32  store data (Val_Rm)
read_data  output  32  load result to MEM/WB register
ready  output  1  1 = no access in flight or access completing; 0 = freeze pipeline
sram_dq  inout  16  SRAM data bus
sram_addr  output  18  SRAM halfword address
sram_we_n  output  1  SRAM write strobe, active low
sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n  output  1 each  tied 0

Behaviour:
Reset
- Synchronous, active-high; clk and rst are the only clock/reset.
- After reset: state IDLE, counter 0, read_data 0, sram_we_n 1, sram_addr 0, sram_dq high-Z, ready per IDLE rule.
- rst asserted mid-access: abort to IDLE next edge, no further SRAM writes. A half-written word is acceptable.

Address mapping
- word_addr = address - BASE_ADDR (32-bit wrap).
- Low half: sram_addr = {word_addr[18:2], 0}.
- High half: sram_addr = {word_addr[18:2], 1}.
- address[1:0] ignored.

States
- IDLE:
  - ready = !(rd_en | wr_en), combinational, so the pipeline freezes in the request cycle.
  - On request: go to LO, counter = 1.
  - If rd_en and wr_en are both set, write has priority.
  - The operation type is latched at entry. Inputs must stay stable while ready=0 (frozen pipeline guarantees this).
- LO: drive low-half address.
  - Write: sram_we_n=0, sram_dq=write_data[15:0].
  - Read: sram_dq Z; capture sram_dq into read_data[15:0] at end of cycle.
  - Go to HI.
- HI: same as LO for the high half.
  - Write: drive write_data[31:16].
  - Read: capture into read_data[31:16].
  - Go to WAIT.
- WAIT:
  - sram_we_n=1, bus Z, counter increments each cycle.
  - Go to DONE when counter reaches ACCESS_CYCLES-1.
  - With ACCESS_CYCLES=3, WAIT is skipped (HI goes directly to DONE).
- DONE:
  - ready=1 for exactly one cycle; read_data valid. Pipeline advances at this edge.
  - Go to IDLE unconditionally. A request seen in the following IDLE cycle belongs to the next instruction.

Timing and outputs
- Latency: request in cycle 0 → ready=1 in cycle ACCESS_CYCLES (default 5).
- ready is 0 in LO, HI and WAIT.
- read_data holds its value until overwritten by the next read. Writes never change it.
- sram_we_n is never low outside LO/HI.
- sram_dq is driven only while sram_we_n=0, so there is no bus contention on reads.

Test Plan:
- Reset hold 2 cycles → read_data=0, sram_we_n=1, sram_dq=Z, ready=1 with no request.
- Write: wr_en=1, address=1024, write_data=0xDEADBEEF.
  - Required: ready=0 in cycles 0–4; cycle 1 sram_addr=0, dq=0xBEEF, we_n=0; cycle 2 sram_addr=1, dq=0xDEAD, we_n=0; ready=1 in cycle 5.
- Read back via SRAM behavioural model: rd_en=1, address=1024 → read_data=0xDEADBEEF when ready rises in cycle 5; we_n stays 1 throughout.
- Address mapping: write 0x12345678 at address 1032 → sram_addr 4 and 5. Read at 1033 (low bits ignored) → 0x12345678.
- Back-to-back: read at 1024 followed immediately by write at 1028.
  - Required: DONE→IDLE→new access; ready=1 exactly one cycle between accesses.
  - Required: second access starts the cycle after DONE.
- Reset mid-access: assert rst in WAIT of a write → next cycle IDLE, we_n=1, ready=1, read_data=0. Also run with ACCESS_CYCLES=3 → ready in cycle 3.
